// File: rtl/top_pkg.sv
// Shared definitions for the ALU/display block: opcodes, flag positions,
// scan divider default and the seven-segment hex decoder.
package top_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd13;

  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_SF = 0;

  localparam int unsigned SCAN_DIV_DEFAULT = 100000;

  // Common-anode pattern, bit order g..a, 0 = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU producing result and ZF/CF/OF/SF flags.
module alu_core
  import top_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] r_o,
  output logic [3:0]  f_o
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [4:0]  shamt;
  logic [31:0] r;
  logic        cf;
  logic        of;
  logic        valid;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    diff  = {1'b0, a_i} - {1'b0, b_i};
    shamt = b_i[4:0];
    r     = '0;
    cf    = 1'b0;
    of    = 1'b0;
    valid = 1'b1;
    case (op_i)
      OP_ADD: begin
        r  = sum[31:0];
        cf = sum[32];
        of = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      // diff[32] is the borrow out of an unsigned subtract
      OP_SUB: begin
        r  = diff[31:0];
        cf = diff[32];
        of = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      OP_SLL:  r = a_i << shamt;
      OP_SLT:  r = {31'd0, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: r = {31'd0, (a_i < b_i)};
      OP_XOR:  r = a_i ^ b_i;
      OP_SRL:  r = a_i >> shamt;
      OP_OR:   r = a_i | b_i;
      OP_AND:  r = a_i & b_i;
      OP_SRA:  r = 32'($signed(a_i) >>> shamt);
      default: valid = 1'b0;
    endcase

    f_o          = '0;
    f_o[FLAG_ZF] = valid & (r == 32'd0);
    f_o[FLAG_CF] = cf;
    f_o[FLAG_OF] = of;
    f_o[FLAG_SF] = valid & r[31];
    r_o          = r;
  end

endmodule

// File: rtl/top.sv
// Switch-loaded ALU: synchronized load strobes, operand/opcode registers,
// registered result/flags and a multiplexed 4-digit hex display.
module top
  import top_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_F,
  input  logic        clk_A,
  input  logic        clk_B,
  input  logic [31:0] SW,
  output logic [3:0]  F,
  output logic [3:0]  AN,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Strobe vector bit order: [0]=A, [1]=B, [2]=F
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] armed_q, armed_d;
  logic [1:0] fill_q, fill_d;
  logic [2:0] load_c;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  f_q, f_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [15:0]      half;
  logic [3:0]       nib;

  alu_core u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .r_o  (r_d),
    .f_o  (f_d)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      armed_q <= '0;
      fill_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      r_q     <= '0;
      f_q     <= 4'b1000;
      cnt_q   <= '0;
      dig_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= {1'b1, hex_to_seg(4'h0)};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      r_q     <= r_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    sync1_d = {clk_F, clk_B, clk_A};
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    // A strobe arms only after a genuine low has passed the synchronizer,
    // so a level still high from before reset cannot trigger a load.
    load_c  = armed_q & sync2_q;
    armed_d = ~sync2_q & (armed_q | {3{fill_q[1]}});

    a_d  = load_c[0] ? SW       : a_q;
    b_d  = load_c[1] ? SW       : b_q;
    op_d = load_c[2] ? SW[3:0]  : op_q;

    cnt_d = cnt_q + CNT_W'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
    an_d = ~(4'b0001 << dig_d);

    half = SW[31] ? r_q[31:16] : r_q[15:0];
    case (dig_d)
      2'd0:    nib = half[3:0];
      2'd1:    nib = half[7:4];
      2'd2:    nib = half[11:8];
      default: nib = half[15:12];
    endcase
    seg_d = {1'b1, hex_to_seg(nib)};
  end

  assign F   = f_q;
  assign AN  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_top.sv
// Randomized and directed bench for top: loads operands through the strobes
// and reads the result back through the scanned display.
module tb_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_F, clk_A, clk_B;
  logic [31:0] SW;
  logic [3:0]  F, AN;
  logic [7:0]  seg;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  top #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_F (clk_F),
    .clk_A (clk_A),
    .clk_B (clk_B),
    .SW    (SW),
    .F     (F),
    .AN    (AN),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: flags and result straight from the arithmetic definitions.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [31:0] r, output logic [3:0] f);
    longint ua, ub, sa, sb, t;
    int     sh;
    logic   cf, of, valid;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    sh = int'(b[4:0]);
    cf = 1'b0; of = 1'b0; valid = 1'b1; r = '0;
    case (op)
      4'd0: begin
        t = ua + ub; r = t[31:0]; cf = (t >= 64'sd4294967296);
        t = sa + sb; of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd8: begin
        t = ua - ub; r = t[31:0]; cf = (ua < ub);
        t = sa - sb; of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd1: begin t = ua * (64'sd1 << sh); r = t[31:0]; end
      4'd2: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd3: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd4: r = a ^ b;
      4'd5: begin t = ua / (64'sd1 << sh); r = t[31:0]; end
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd13: begin
        t = sa / (64'sd1 << sh);
        if (sa < 0 && (sa % (64'sd1 << sh)) != 0) t = t - 1;
        r = t[31:0];
      end
      default: valid = 1'b0;
    endcase
    f = valid ? {(r == 32'd0), cf, of, r[31]} : 4'b0000;
  endtask

  function automatic logic [3:0] seg2nib(input logic [7:0] s);
    logic [3:0] n;
    n = 'x;
    for (int i = 0; i < 16; i++) if (SEG_TAB[i] === s) n = 4'(i);
    return n;
  endfunction

  task automatic pulse(input logic [2:0] which, input logic [31:0] val, input int hold);
    @(negedge clk);
    SW = val;
    {clk_F, clk_B, clk_A} = which;
    repeat (hold) @(negedge clk);
    {clk_F, clk_B, clk_A} = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    pulse(3'b001, a, 2);
    pulse(3'b010, b, 2);
    pulse(3'b100, {28'd0, op}, 2);
    repeat (2) @(negedge clk);
  endtask

  task automatic read_r(output logic [31:0] r);
    logic [3:0] pat;
    int n;
    r = '0;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      SW[31] = h[0];
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        pat = ~(4'b0001 << d);
        n = 0;
        while (AN !== pat && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("an_wait", {28'd0, AN}, {28'd0, pat});
        r[16*h + 4*d +: 4] = seg2nib(seg);
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
    logic [31:0] er, gr;
    logic [3:0]  ef;
    apply(a, b, op);
    model(a, b, op, er, ef);
    check({tag, "_F"}, {28'd0, F}, {28'd0, ef});
    read_r(gr);
    check({tag, "_R"}, gr, er);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    logic [31:0] gr, ra, rb;
    logic [3:0]  rop;
    rst_n = 1'b1;
    {clk_F, clk_B, clk_A} = 3'b000;
    SW = '0;
    do_reset();

    check("rst_F", {28'd0, F}, 32'h8);
    check("rst_AN", {28'd0, AN}, 32'hE);
    check("rst_seg", {24'd0, seg}, 32'hC0);
    // Digit advances every 4 clocks starting from the reset release.
    for (int i = 0; i < 16; i++) begin
      check("scan", {28'd0, AN}, {28'd0, ~(4'b0001 << (i / 4))});
      @(negedge clk);
    end

    run_case("add_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0);
    do_reset();
    run_case("add_1_1", 32'd1, 32'd1, 4'd0);
    check("add_1_1_exp", {28'd0, F}, 32'h0);
    run_case("sll", 32'd1, 32'd2, 4'd1);
    run_case("slt_neg", 32'hA000_0001, 32'd1, 4'd2);
    run_case("slt_pos", 32'd2, 32'd1, 4'd2);
    run_case("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0);
    run_case("sub_brw", 32'd0, 32'd1, 4'd8);
    run_case("sra", 32'h8000_00F0, 32'd4, 4'd13);
    run_case("bad_op", 32'd0, 32'd0, 4'd9);

    // Long strobe loads once: SW changes mid-pulse must not reach A.
    apply(32'd0, 32'd0, 4'd0);
    @(negedge clk);
    SW = 32'h0000_0005;
    clk_A = 1'b1;
    repeat (5) @(negedge clk);
    SW = 32'h0000_0009;
    repeat (5) @(negedge clk);
    clk_A = 1'b0;
    repeat (4) @(negedge clk);
    read_r(gr);
    check("hold_once", gr, 32'h5);

    // Reset while a strobe is high: the pulse is discarded.
    @(negedge clk);
    SW = 32'h0000_0033;
    clk_A = 1'b1;
    @(negedge clk);
    do_reset();
    repeat (8) @(negedge clk);
    clk_A = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pulse_F", {28'd0, F}, 32'h8);
    read_r(gr);
    check("rst_pulse_R", gr, 32'h0);
    pulse(3'b001, 32'h0000_0033, 2);
    repeat (2) @(negedge clk);
    read_r(gr);
    check("reload_R", gr, 32'h33);

    // Simultaneous A and B strobes share the same SW value.
    pulse(3'b011, 32'h1234_0001, 2);
    repeat (2) @(negedge clk);
    read_r(gr);
    check("simul_R", gr, 32'h2468_0002);

    for (int k = 0; k < 40; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 15));
      if (k % 8 == 0) ra = 32'h8000_0000;
      if (k % 8 == 1) rb = ra;
      run_case("rand", ra, rb, rop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
